// File: rtl/mem_wb_lsu_stage_if.sv
// Bundle of MEM-side request and WB-side result signals for the MEM->WB stage.
// master = the side feeding the stage (core/bench), slave = the stage itself.
interface mem_wb_lsu_stage_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  localparam int LOW = $clog2(XLEN / 8);

  logic            m_valid;
  logic            m_ready;
  logic [AW-1:0]   m_rd;
  logic            m_we;
  logic            m_ld;
  logic            m_jal;
  logic            m_lui;
  logic [2:0]      m_op;
  logic [LOW-1:0]  m_addr_lo;
  logic [XLEN-1:0] m_alu;
  logic [XLEN-1:0] m_imm;
  logic [XLEN-1:0] m_pc4;
  logic [XLEN-1:0] m_rdata;
  logic            w_valid;
  logic            w_ready;
  logic [AW-1:0]   w_rd;
  logic            w_we;
  logic [XLEN-1:0] w_data;
  logic            w_misalign;

  modport master (
    output m_valid, m_rd, m_we, m_ld, m_jal, m_lui, m_op, m_addr_lo,
           m_alu, m_imm, m_pc4, m_rdata, w_ready,
    input  m_ready, w_valid, w_rd, w_we, w_data, w_misalign
  );

  modport slave (
    input  m_valid, m_rd, m_we, m_ld, m_jal, m_lui, m_op, m_addr_lo,
           m_alu, m_imm, m_pc4, m_rdata, w_ready,
    output m_ready, w_valid, w_rd, w_we, w_data, w_misalign
  );
endinterface

// File: rtl/mem_wb_lsu_stage.sv
// MEM->WB stage: two-slot in-order holding FIFO that captures sync-read load data,
// aligns and extends it, flags misaligned loads and performs the final writeback select.
module mem_wb_lsu_stage #(
  parameter int XLEN    = 32,
  parameter int AW      = 5,
  parameter bit SKID_EN = 1'b1
) (
  input logic MEM_WB_clk,
  input logic MEM_WB_rst_n,
  input logic MEM_WB_flush,
  mem_wb_lsu_stage_if.slave bus
);
  localparam int LOW = $clog2(XLEN / 8);
  localparam bit IS64 = (XLEN == 64);
  localparam logic [1:0] CAP = SKID_EN ? 2'd2 : 2'd1;

  // Non-load results are resolved at accept time; loads keep their decode fields
  // and wait one cycle for the RAM word.
  logic [AW-1:0]   ent_rd   [2];
  logic            ent_we   [2];
  logic            ent_ld   [2];
  logic [2:0]      ent_op   [2];
  logic [LOW-1:0]  ent_lo   [2];
  logic [XLEN-1:0] ent_val  [2];
  logic [XLEN-1:0] ent_data [2];
  logic [1:0]      pend;
  logic [1:0]      count;
  logic [1:0]      count_nxt;
  logic            wr_ptr;
  logic            rd_ptr;
  logic            m_ready_q;
  logic            head_valid;
  logic            accept;
  logic            pop;

  assign head_valid  = (count != 2'd0);
  assign bus.m_ready = SKID_EN ? m_ready_q : ((count < CAP) | bus.w_ready);
  assign accept      = bus.m_valid & bus.m_ready & ~MEM_WB_flush;
  assign pop         = head_valid & bus.w_ready & ~MEM_WB_flush;

  always_comb begin
    count_nxt = count;
    if (MEM_WB_flush)
      count_nxt = 2'd0;
    else if (accept && !pop)
      count_nxt = count + 2'd1;
    else if (pop && !accept)
      count_nxt = count - 2'd1;
  end

  // Writes alternate slots, so the slot being filled never collides with the
  // slot that captures its RAM word on the following edge.
  always_ff @(posedge MEM_WB_clk or negedge MEM_WB_rst_n) begin
    if (!MEM_WB_rst_n) begin
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      pend      <= 2'b00;
      m_ready_q <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        ent_rd[i]   <= '0;
        ent_we[i]   <= 1'b0;
        ent_ld[i]   <= 1'b0;
        ent_op[i]   <= 3'd0;
        ent_lo[i]   <= '0;
        ent_val[i]  <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      count     <= count_nxt;
      m_ready_q <= (count_nxt < 2'd2);
      if (MEM_WB_flush) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        pend   <= 2'b00;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (pend[i]) begin
            ent_data[i] <= bus.m_rdata;
            pend[i]     <= 1'b0;
          end
        end
        if (accept) begin
          ent_rd[wr_ptr]  <= bus.m_rd;
          ent_we[wr_ptr]  <= bus.m_we;
          ent_ld[wr_ptr]  <= bus.m_ld;
          ent_op[wr_ptr]  <= bus.m_op;
          ent_lo[wr_ptr]  <= bus.m_addr_lo;
          ent_val[wr_ptr] <= bus.m_jal ? bus.m_pc4 : (bus.m_lui ? bus.m_imm : bus.m_alu);
          pend[wr_ptr]    <= 1'b1;
          wr_ptr          <= ~wr_ptr;
        end
        if (pop)
          rd_ptr <= ~rd_ptr;
      end
    end
  end

  logic [XLEN-1:0] raw;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] ext;
  logic [LOW-1:0]  lo;
  logic [1:0]      size;
  logic            uns;
  logic            mis;

  // A head still waiting on its RAM word reads the live bus; on RV32 LD/LWU fold into LW.
  always_comb begin
    raw     = pend[rd_ptr] ? bus.m_rdata : ent_data[rd_ptr];
    lo      = ent_lo[rd_ptr];
    shifted = raw >> {lo, 3'b000};
    size    = ent_op[rd_ptr][1:0];
    uns     = ent_op[rd_ptr][2];
    if (!IS64 && size == 2'd3)
      size = 2'd2;
    if (!IS64 && size == 2'd2)
      uns = 1'b0;
    case (size)
      2'd1:    mis = lo[0];
      2'd2:    mis = (lo[1:0] != 2'd0);
      2'd3:    mis = (lo != '0);
      default: mis = 1'b0;
    endcase
    mis = mis & ent_ld[rd_ptr];
    case (size)
      2'd0:    ext = uns ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
      2'd1:    ext = uns ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
      2'd2:    ext = uns ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
      default: ext = shifted;
    endcase
  end

  assign bus.w_valid    = head_valid;
  assign bus.w_rd       = head_valid ? ent_rd[rd_ptr] : '0;
  assign bus.w_we       = head_valid & ent_we[rd_ptr] & ~mis;
  assign bus.w_misalign = head_valid & mis;
  assign bus.w_data     = !head_valid ? '0 :
                          (ent_ld[rd_ptr] ? (mis ? '0 : ext) : ent_val[rd_ptr]);
endmodule

// File: tb/tb_mem_wb_lsu_stage.sv
// Scoreboard bench: one RV32 and one RV64 stage share stimulus; a reference model
// predicts each writeback at acceptance and per-width monitors compare on every pop.
module tb_mem_wb_lsu_stage;
  typedef struct packed {
    logic [4:0]  rd;
    logic        we;
    logic        ld;
    logic        jal;
    logic        lui;
    logic [2:0]  op;
    logic [2:0]  lo;
    logic [63:0] alu;
    logic [63:0] imm;
    logic [63:0] pc4;
    logic [63:0] rdata;
  } inst_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic        we;
    logic        mis;
    logic [63:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        mValid;
  logic        wReady;
  inst_t       cur;
  logic [63:0] rdataBus;
  logic [63:0] junkRdata;
  int          checks;
  int          errors;
  exp_t        q32[$];
  exp_t        q64[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_wb_lsu_stage_if #(.XLEN(32), .AW(5)) if32();
  mem_wb_lsu_stage_if #(.XLEN(64), .AW(5)) if64();

  assign if32.m_valid   = mValid;
  assign if32.m_rd      = cur.rd;
  assign if32.m_we      = cur.we;
  assign if32.m_ld      = cur.ld;
  assign if32.m_jal     = cur.jal;
  assign if32.m_lui     = cur.lui;
  assign if32.m_op      = cur.op;
  assign if32.m_addr_lo = cur.lo[1:0];
  assign if32.m_alu     = cur.alu[31:0];
  assign if32.m_imm     = cur.imm[31:0];
  assign if32.m_pc4     = cur.pc4[31:0];
  assign if32.m_rdata   = rdataBus[31:0];
  assign if32.w_ready   = wReady;

  assign if64.m_valid   = mValid;
  assign if64.m_rd      = cur.rd;
  assign if64.m_we      = cur.we;
  assign if64.m_ld      = cur.ld;
  assign if64.m_jal     = cur.jal;
  assign if64.m_lui     = cur.lui;
  assign if64.m_op      = cur.op;
  assign if64.m_addr_lo = cur.lo;
  assign if64.m_alu     = cur.alu;
  assign if64.m_imm     = cur.imm;
  assign if64.m_pc4     = cur.pc4;
  assign if64.m_rdata   = rdataBus;
  assign if64.w_ready   = wReady;

  mem_wb_lsu_stage #(.XLEN(32), .AW(5), .SKID_EN(1'b1)) dut32 (
    .MEM_WB_clk   (clk),
    .MEM_WB_rst_n (rst_n),
    .MEM_WB_flush (flush),
    .bus          (if32)
  );

  mem_wb_lsu_stage #(.XLEN(64), .AW(5), .SKID_EN(1'b1)) dut64 (
    .MEM_WB_clk   (clk),
    .MEM_WB_rst_n (rst_n),
    .MEM_WB_flush (flush),
    .bus          (if64)
  );

  // Reference: pick the access width, slice by byte lane, extend, then writeback priority.
  function automatic exp_t refModel(input inst_t in, input bit is64);
    exp_t        e;
    int          nb;
    int          lane;
    bit          sgn;
    logic [63:0] wmask;
    logic [63:0] fmask;
    logic [63:0] word;
    logic [63:0] val;
    wmask = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    word  = in.rdata & wmask;
    lane  = is64 ? int'(in.lo) : int'(in.lo[1:0]);
    case (in.op[1:0])
      2'd0:    nb = 1;
      2'd1:    nb = 2;
      2'd2:    nb = 4;
      default: nb = 8;
    endcase
    sgn = (in.op[2] == 1'b0);
    if (!is64 && nb == 8) nb = 4;
    if (!is64 && in.op == 3'b110) sgn = 1'b1;
    fmask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (nb * 8)) - 64'd1);
    val = (word >> (lane * 8)) & fmask;
    if (sgn && val[nb*8-1]) val = val | ~fmask;
    e.mis = in.ld && ((lane % nb) != 0);
    if (in.ld)       e.data = e.mis ? 64'd0 : val;
    else if (in.jal) e.data = in.pc4;
    else if (in.lui) e.data = in.imm;
    else             e.data = in.alu;
    e.data = e.data & wmask;
    e.we   = in.we && !e.mis;
    e.rd   = in.rd;
    return e;
  endfunction

  function automatic inst_t mkInst(input bit ld, input bit jal, input bit lui, input logic [2:0] op,
                                   input logic [2:0] lo, input logic [63:0] val, input logic [63:0] rdata);
    inst_t r;
    r.rd    = 5'($urandom_range(1, 31));
    r.we    = 1'b1;
    r.ld    = ld;
    r.jal   = jal;
    r.lui   = lui;
    r.op    = op;
    r.lo    = lo;
    r.alu   = val;
    r.imm   = val ^ 64'h5A5A_5A5A_5A5A_5A5A;
    r.pc4   = val + 64'd4;
    r.rdata = rdata;
    return r;
  endfunction

  function automatic inst_t randInst();
    inst_t r;
    r.rd    = 5'($urandom);
    r.we    = 1'($urandom);
    r.ld    = ($urandom_range(0, 1) == 1);
    r.jal   = ($urandom_range(0, 3) == 0);
    r.lui   = ($urandom_range(0, 3) == 0);
    r.op    = 3'($urandom_range(0, 6));
    r.lo    = 3'($urandom_range(0, 7));
    r.alu   = {$urandom, $urandom};
    r.imm   = {$urandom, $urandom};
    r.pc4   = {$urandom, $urandom};
    r.rdata = {$urandom, $urandom};
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // One clock of stimulus; predictions are pushed at the edge that accepts.
  task automatic applyStimulus(input bit v, input inst_t in, input bit fl, output bit acc);
    bit a32;
    bit a64;
    mValid = v;
    cur    = in;
    flush  = fl;
    @(negedge clk);
    a32 = v && if32.m_ready && !fl;
    a64 = v && if64.m_ready && !fl;
    if (fl) begin
      q32.delete();
      q64.delete();
    end
    if (a32) q32.push_back(refModel(in, 1'b0));
    if (a64) q64.push_back(refModel(in, 1'b1));
    acc = a32 && a64;
    @(posedge clk);
    #1;
    rdataBus = (a32 || a64) ? in.rdata : junkRdata;
    mValid   = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic issue(input inst_t in);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      applyStimulus(1'b1, in, 1'b0, acc);
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL issue_timeout: got accepted=0, expected accepted=1");
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, cur, 1'b0, acc);
  endtask

  task automatic drain();
    bit acc;
    int n;
    n      = 0;
    wReady = 1'b1;
    while ((q32.size() != 0 || q64.size() != 0) && n < 50) begin
      applyStimulus(1'b0, cur, 1'b0, acc);
      n++;
    end
    if (q32.size() != 0 || q64.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d/%0d outstanding, expected 0", q32.size(), q64.size());
    end
  endtask

  always @(negedge clk) begin : monitor32
    exp_t e;
    if (rst_n && !flush && if32.w_valid && if32.w_ready) begin
      if (q32.size() == 0) begin
        checkOutput("x32_unexpected_pop", 64'd1, 64'd0);
      end else begin
        e = q32.pop_front();
        checkOutput("x32_w_data", {32'h0, if32.w_data}, e.data);
        checkOutput("x32_rd_we_mis", {57'h0, if32.w_rd, if32.w_we, if32.w_misalign},
                    {57'h0, e.rd, e.we, e.mis});
      end
    end
  end

  always @(negedge clk) begin : monitor64
    exp_t e;
    if (rst_n && !flush && if64.w_valid && if64.w_ready) begin
      if (q64.size() == 0) begin
        checkOutput("x64_unexpected_pop", 64'd1, 64'd0);
      end else begin
        e = q64.pop_front();
        checkOutput("x64_w_data", if64.w_data, e.data);
        checkOutput("x64_rd_we_mis", {57'h0, if64.w_rd, if64.w_we, if64.w_misalign},
                    {57'h0, e.rd, e.we, e.mis});
      end
    end
  end

  initial begin
    bit          acc;
    logic [63:0] w1;
    logic [63:0] w2;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    mValid    = 1'b0;
    wReady    = 1'b1;
    cur       = '0;
    rdataBus  = 64'd0;
    junkRdata = 64'h0000_0000_0000_DEAD;

    #12;
    checkOutput("rst32_m_ready", {63'h0, if32.m_ready}, 64'd1);
    checkOutput("rst32_w_valid", {63'h0, if32.w_valid}, 64'd0);
    checkOutput("rst32_w_data", {32'h0, if32.w_data}, 64'd0);
    checkOutput("rst32_w_ctl", {57'h0, if32.w_rd, if32.w_we, if32.w_misalign}, 64'd0);
    checkOutput("rst64_m_ready", {63'h0, if64.m_ready}, 64'd1);
    checkOutput("rst64_w_valid", {63'h0, if64.w_valid}, 64'd0);
    checkOutput("rst64_w_data", if64.w_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed load extraction");
    w1 = 64'h0000_0000_80AB_CDEF;
    w2 = 64'h8000_0000_1234_5678;
    issue(mkInst(1'b1, 1'b0, 1'b0, 3'b000, 3'd3, 64'h11, w1));
    issue(mkInst(1'b1, 1'b0, 1'b0, 3'b100, 3'd3, 64'h12, w1));
    issue(mkInst(1'b1, 1'b0, 1'b0, 3'b001, 3'd2, 64'h13, w1));
    issue(mkInst(1'b1, 1'b0, 1'b0, 3'b101, 3'd2, 64'h14, w1));
    issue(mkInst(1'b1, 1'b0, 1'b0, 3'b010, 3'd0, 64'h15, w1));
    issue(mkInst(1'b1, 1'b0, 1'b0, 3'b010, 3'd2, 64'h16, w1));
    issue(mkInst(1'b1, 1'b0, 1'b0, 3'b010, 3'd4, 64'h17, w2));
    issue(mkInst(1'b1, 1'b0, 1'b0, 3'b110, 3'd4, 64'h18, w2));
    issue(mkInst(1'b1, 1'b0, 1'b0, 3'b011, 3'd0, 64'h19, w2));
    issue(mkInst(1'b1, 1'b0, 1'b0, 3'b011, 3'd4, 64'h1A, w2));
    issue(mkInst(1'b0, 1'b1, 1'b0, 3'b000, 3'd0, 64'h100, w2));
    issue(mkInst(1'b0, 1'b0, 1'b1, 3'b000, 3'd0, 64'h200, w2));
    drain();

    $display("[TB] back-pressure ordering");
    wReady = 1'b0;
    issue(mkInst(1'b0, 1'b0, 1'b0, 3'b000, 3'd0, 64'd1, 64'd0));
    issue(mkInst(1'b0, 1'b0, 1'b0, 3'b000, 3'd0, 64'd2, 64'd0));
    idle(1);
    checkOutput("bp32_m_ready_full", {63'h0, if32.m_ready}, 64'd0);
    checkOutput("bp64_m_ready_full", {63'h0, if64.m_ready}, 64'd0);
    wReady = 1'b1;
    issue(mkInst(1'b0, 1'b0, 1'b0, 3'b000, 3'd0, 64'd3, 64'd0));
    drain();

    $display("[TB] late pop of a captured load");
    wReady = 1'b0;
    issue(mkInst(1'b1, 1'b0, 1'b0, 3'b010, 3'd0, 64'h21, 64'h0000_0000_0000_1234));
    idle(3);
    drain();

    $display("[TB] flush with held entries and incoming valid");
    wReady = 1'b0;
    issue(mkInst(1'b0, 1'b0, 1'b0, 3'b000, 3'd0, 64'd5, 64'd0));
    issue(mkInst(1'b0, 1'b0, 1'b0, 3'b000, 3'd0, 64'd6, 64'd0));
    applyStimulus(1'b1, mkInst(1'b0, 1'b0, 1'b0, 3'b000, 3'd0, 64'd7, 64'd0), 1'b1, acc);
    checkOutput("flush32_w_valid", {63'h0, if32.w_valid}, 64'd0);
    checkOutput("flush64_w_valid", {63'h0, if64.w_valid}, 64'd0);
    wReady = 1'b1;
    idle(3);

    $display("[TB] reset mid-stream");
    wReady = 1'b0;
    issue(mkInst(1'b0, 1'b0, 1'b0, 3'b000, 3'd0, 64'd8, 64'd0));
    issue(mkInst(1'b0, 1'b0, 1'b0, 3'b000, 3'd0, 64'd9, 64'd0));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mrst32_w_valid", {63'h0, if32.w_valid}, 64'd0);
    checkOutput("mrst32_w_data", {32'h0, if32.w_data}, 64'd0);
    checkOutput("mrst32_m_ready", {63'h0, if32.m_ready}, 64'd1);
    checkOutput("mrst64_w_valid", {63'h0, if64.w_valid}, 64'd0);
    checkOutput("mrst64_w_data", if64.w_data, 64'd0);
    checkOutput("mrst64_m_ready", {63'h0, if64.m_ready}, 64'd1);
    q32.delete();
    q64.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      wReady    = ($urandom_range(0, 3) != 0);
      junkRdata = {$urandom, $urandom};
      applyStimulus(($urandom_range(0, 2) != 0), randInst(), ($urandom_range(0, 39) == 0), acc);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
